// File: rtl/fp_double_pkg.sv
// Shared IEEE-754 double-precision type and helpers for the fp_double datapath.
package fp_double;
    typedef logic [63:0] double;

    localparam double DOUBLE_ZERO     = 64'h0000_0000_0000_0000;
    localparam double DOUBLE_ABS_MASK = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam double DOUBLE_QNAN     = 64'h7FF8_0000_0000_0000;

    function automatic logic [10:0] double_exp(input double d);
        return 11'(d >> 52);
    endfunction
endpackage

// File: rtl/fp_div.sv
// Pipelined double-precision divider (vendor IP model), round-to-nearest-even, subnormals flushed to zero.
// Latency: LATENCY clock-enabled cycles from dataa/datab to result and flags.
// Backpressure: none; the pipeline only advances while clk_en is high.
module fp_div
    import fp_double::*;
#(
    parameter int LATENCY = 10
) (
    input  logic  aclr,
    input  logic  clock,
    input  logic  clk_en,
    input  double dataa,
    input  double datab,
    output double result,
    output logic  overflow,
    output logic  nan,
    output logic  zero,
    output logic  division_by_zero
);
    typedef struct packed {
        double q;
        logic  ovf;
        logic  nan;
        logic  zro;
        logic  dbz;
    } div_out_t;

    div_out_t stage_in;
    div_out_t pipe [LATENCY];

    logic [10:0]        ea, eb;
    logic               a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, sq;
    logic [108:0]       num, den;
    logic [56:0]        quo;
    logic [52:0]        rem, mant;
    logic               guard, sticky;
    logic signed [12:0] exp_q, exp_r;
    logic [53:0]        mant_r;
    logic [51:0]        frac;

    always_comb begin
        ea     = double_exp(dataa);
        eb     = double_exp(datab);
        a_nan  = (ea == 11'h7FF) && (dataa[51:0] != '0);
        a_inf  = (ea == 11'h7FF) && (dataa[51:0] == '0);
        a_zero = (ea == '0);
        b_nan  = (eb == 11'h7FF) && (datab[51:0] != '0);
        b_inf  = (eb == 11'h7FF) && (datab[51:0] == '0);
        b_zero = (eb == '0);
        sq     = dataa[63] ^ datab[63];
        // Mantissa ratio lies in (0.5, 2): quotient carries 55..56 significant bits plus guard/sticky.
        num = {1'b1, dataa[51:0], 56'b0};
        den = {56'b0, 1'b1, datab[51:0]};
        quo = 57'(num / den);
        rem = 53'(num % den);
        if (quo[56]) begin
            mant   = quo[56:4];
            guard  = quo[3];
            sticky = (quo[2:0] != '0) || (rem != '0);
            exp_q  = $signed({2'b0, ea}) - $signed({2'b0, eb}) + 13'sd1023;
        end else begin
            mant   = quo[55:3];
            guard  = quo[2];
            sticky = (quo[1:0] != '0) || (rem != '0);
            exp_q  = $signed({2'b0, ea}) - $signed({2'b0, eb}) + 13'sd1022;
        end
        mant_r = {1'b0, mant} + 54'(guard && (sticky || mant[0]));
        frac   = mant_r[53] ? mant_r[52:1] : mant_r[51:0];
        exp_r  = mant_r[53] ? exp_q + 13'sd1 : exp_q;

        stage_in = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            stage_in.q   = DOUBLE_QNAN;
            stage_in.nan = 1'b1;
        end else if (a_inf || b_zero) begin
            stage_in.q   = {sq, 11'h7FF, 52'b0};
            stage_in.dbz = b_zero && !a_inf;
        end else if (a_zero || b_inf) begin
            stage_in.q   = {sq, 63'b0};
            stage_in.zro = 1'b1;
        end else if (exp_r >= 13'sd2047) begin
            stage_in.q   = {sq, 11'h7FF, 52'b0};
            stage_in.ovf = 1'b1;
        end else if (exp_r <= 13'sd0) begin
            stage_in.q   = {sq, 63'b0};
            stage_in.zro = 1'b1;
        end else begin
            stage_in.q   = {sq, exp_r[10:0], frac};
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
        end else if (clk_en) begin
            pipe[0] <= stage_in;
            for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign result           = pipe[LATENCY-1].q;
    assign overflow         = pipe[LATENCY-1].ovf;
    assign nan              = pipe[LATENCY-1].nan;
    assign zero             = pipe[LATENCY-1].zro;
    assign division_by_zero = pipe[LATENCY-1].dbz;
endmodule

// File: rtl/double_matrix_normalise.sv
// Divides a SIZE_A x SIZE_B double matrix by |norm|, streaming elements through one fp_div; err needs DOUBLE_NORMALISE_ERR_EN.
// Latency: f high after E0+N+CYCLES_D+1 (E0+2 for zero/subnormal norm).
// Backpressure: start is ignored while busy; no downstream stall.
module double_matrix_normalise
    import fp_double::*;
#(
    parameter int SIZE_A   = 8,
    parameter int SIZE_B   = 8,
    parameter int CYCLES_D = 10
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  start,
    input  double mat    [SIZE_A][SIZE_B],
    input  double norm,
    output double result [SIZE_A][SIZE_B],
    output logic  busy,
    output logic  f,
    output logic  zero_norm,
    output logic  err
);
    localparam int N  = SIZE_A * SIZE_B;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
    localparam int CW = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t        state;
    double         mat_q [SIZE_A][SIZE_B];
    double         norm_q;
    logic [IW-1:0] k;
    logic          vld_sr [CYCLES_D];
    logic [IW-1:0] idx_sr [CYCLES_D];
    logic          zero_pend;
    logic          div_en, wr_en, accept;
    double         div_q;
    logic [RW-1:0] k_row, o_row;
    logic [CW-1:0] k_col, o_col;
    logic          div_zero_unused, div_dbz_unused;
`ifdef DOUBLE_NORMALISE_ERR_EN
    logic          div_ovf, div_nan;
`else
    logic          div_ovf_unused, div_nan_unused;
`endif

    assign accept = (state == IDLE) && start;
    assign div_en = (state == ISSUE) || (state == DRAIN);
    assign wr_en  = div_en && vld_sr[CYCLES_D-1];
    assign k_row  = RW'(32'(k) / SIZE_B);
    assign k_col  = CW'(32'(k) % SIZE_B);
    assign o_row  = RW'(32'(idx_sr[CYCLES_D-1]) / SIZE_B);
    assign o_col  = CW'(32'(idx_sr[CYCLES_D-1]) % SIZE_B);

    fp_div #(.LATENCY(CYCLES_D)) u_div (
        .aclr             (rst),
        .clock            (clk),
        .clk_en           (div_en),
        .dataa            (mat_q[k_row][k_col]),
        .datab            (norm_q),
        .result           (div_q),
`ifdef DOUBLE_NORMALISE_ERR_EN
        .overflow         (div_ovf),
        .nan              (div_nan),
`else
        .overflow         (div_ovf_unused),
        .nan              (div_nan_unused),
`endif
        .zero             (div_zero_unused),
        .division_by_zero (div_dbz_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            f         <= 1'b0;
            zero_norm <= 1'b0;
            zero_pend <= 1'b0;
            k         <= '0;
            norm_q    <= DOUBLE_ZERO;
            for (int i = 0; i < SIZE_A; i++)
                for (int j = 0; j < SIZE_B; j++) begin
                    result[i][j] <= DOUBLE_ZERO;
                    mat_q[i][j]  <= DOUBLE_ZERO;
                end
            for (int i = 0; i < CYCLES_D; i++) begin
                vld_sr[i] <= 1'b0;
                idx_sr[i] <= '0;
            end
        end else begin
            // Index/valid tags march in lockstep with the divider pipeline.
            if (div_en) begin
                vld_sr[0] <= (state == ISSUE);
                idx_sr[0] <= k;
                for (int i = 1; i < CYCLES_D; i++) begin
                    vld_sr[i] <= vld_sr[i-1];
                    idx_sr[i] <= idx_sr[i-1];
                end
            end
            if (wr_en) result[o_row][o_col] <= div_q;

            case (state)
                IDLE: if (start) begin
                    mat_q     <= mat;
                    norm_q    <= norm & DOUBLE_ABS_MASK;
                    f         <= 1'b0;
                    busy      <= 1'b1;
                    k         <= '0;
                    zero_norm <= (double_exp(norm) == '0);
                    zero_pend <= (double_exp(norm) == '0);
                    state     <= (double_exp(norm) == '0) ? DONE : ISSUE;
                end
                ISSUE: begin
                    if (k == IW'(N-1)) state <= DRAIN;
                    else               k     <= k + 1'b1;
                end
                DRAIN: if (wr_en && (idx_sr[CYCLES_D-1] == IW'(N-1))) state <= DONE;
                DONE: begin
                    // Zero-norm runs spend one DONE cycle clearing the result array.
                    if (zero_pend) begin
                        zero_pend <= 1'b0;
                        for (int i = 0; i < SIZE_A; i++)
                            for (int j = 0; j < SIZE_B; j++) result[i][j] <= DOUBLE_ZERO;
                    end else begin
                        f     <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DOUBLE_NORMALISE_ERR_EN
    always_ff @(posedge clk) begin
        if (rst || accept) err <= 1'b0;
        else if (wr_en)    err <= err | div_ovf | div_nan;
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_double_matrix_normalise.sv
// Bench for double_matrix_normalise: table of runs plus hand-built timing, ignored-start and reset sequences.
module tb_double_matrix_normalise;
    import fp_double::*;

    localparam int SA = 8;
    localparam int SB = 8;
    localparam int CD = 10;
    localparam int NL = SA * SB + CD + 1;

    logic  clk = 1'b0;
    logic  rst, start;
    double mat    [SA][SB];
    double norm;
    double result [SA][SB];
    logic  busy, f, zero_norm, err;

    int    nvec = 0;
    int    nmis = 0;
    double exp_q [$];
    bit    mon_zero = 1'b0;
    bit    en_seen  = 1'b0;

    typedef struct {
        double fill;
        double nrm;
        bit    ramp;
        bit    rnd;
        int    lat;
        bit    zn;
    } vec_t;
    vec_t tbl [6];

    always #5 clk = ~clk;

    double_matrix_normalise #(.SIZE_A(SA), .SIZE_B(SB), .CYCLES_D(CD)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mat       (mat),
        .norm      (norm),
        .result    (result),
        .busy      (busy),
        .f         (f),
        .zero_norm (zero_norm),
        .err       (err)
    );

    always @(negedge clk) if (mon_zero && dut.u_div.clk_en) en_seen = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic count_nonzero(input string name);
        int nz = 0;
        for (int i = 0; i < SA; i++)
            for (int j = 0; j < SB; j++) if (result[i][j] !== 64'h0) nz++;
        check(name, 64'(nz), 64'h0);
    endtask

    // Drives a run and queues the expected matrix; returns at E0+#1.
    task automatic drive(input double fill, input double nrm, input bit ramp, input bit rnd, input bit big00);
        double nabs = nrm & 64'h7FFF_FFFF_FFFF_FFFF;
        bit    zn   = (nrm[62:52] == 11'd0);
        for (int i = 0; i < SA; i++)
            for (int j = 0; j < SB; j++) begin
                if (ramp)     mat[i][j] = $realtobits(real'(i * SB + j));
                else if (rnd) mat[i][j] = {$urandom, $urandom};
                else          mat[i][j] = fill;
                if (big00 && i == 0 && j == 0) mat[i][j] = $realtobits(1.0e308);
                exp_q.push_back(zn ? 64'h0 : $realtobits($bitstoreal(mat[i][j]) / $bitstoreal(nabs)));
            end
        norm  = nrm;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_accept", busy, 64'h1);
        check("f_cleared_on_accept", f, 64'h0);
    endtask

    task automatic wait_f(input int lat0, input int exp_lat, input bit exp_zn, input bit exp_err, input string tag);
        int lat = lat0;
        while (f !== 1'b1 && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_f_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_zero_norm"}, zero_norm, 64'(exp_zn));
        check({tag, "_busy_low"}, busy, 64'h0);
        check({tag, "_err"}, err, 64'(exp_err));
        for (int i = 0; i < SA; i++)
            for (int j = 0; j < SB; j++) begin
                if (exp_q.size() == 0) begin
                    nvec++;
                    nmis++;
                    $display("FAIL %s_scoreboard: got empty queue expected entry r%0d c%0d", tag, i, j);
                end else begin
                    check($sformatf("%s_r%0d_c%0d", tag, i, j), result[i][j], exp_q.pop_front());
                end
            end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish before 500us");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{$realtobits(2.0),  $realtobits(16.0), 1'b0, 1'b0, NL, 1'b0};
        tbl[1] = '{64'h0,             $realtobits(4.0),  1'b1, 1'b0, NL, 1'b0};
        tbl[2] = '{64'h0,             64'h0,             1'b0, 1'b1, 2,  1'b1};
        tbl[3] = '{$realtobits(-6.0), $realtobits(-2.0), 1'b0, 1'b0, NL, 1'b0};
        tbl[4] = '{$realtobits(3.0),  $realtobits(3.0),  1'b0, 1'b0, NL, 1'b0};
        tbl[5] = '{$realtobits(7.5),  64'h1,             1'b0, 1'b0, 2,  1'b1};

        rst   = 1'b1;
        start = 1'b0;
        norm  = 64'h0;
        for (int i = 0; i < SA; i++)
            for (int j = 0; j < SB; j++) mat[i][j] = 64'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_busy", busy, 64'h0);
        check("reset_f", f, 64'h0);
        check("reset_zero_norm", zero_norm, 64'h0);
        check("reset_err", err, 64'h0);
        count_nonzero("reset_result_nonzero_count");

        // Table runs back-to-back: each start is accepted on the edge after f rises.
        for (int t = 0; t < 6; t++) begin
            mon_zero = tbl[t].zn;
            en_seen  = 1'b0;
            drive(tbl[t].fill, tbl[t].nrm, tbl[t].ramp, tbl[t].rnd, 1'b0);
            wait_f(0, tbl[t].lat, tbl[t].zn, 1'b0, $sformatf("vec%0d", t));
            if (tbl[t].zn) check($sformatf("vec%0d_div_clk_en_seen", t), 64'(en_seen), 64'h0);
            mon_zero = 1'b0;
        end

        drive($realtobits(2.0), $realtobits(16.0), 1'b0, 1'b0, 1'b0);
        wait_f(0, NL, 1'b0, 1'b0, "eighth");
        check("eighth_constant", result[3][5], 64'h3FC0_0000_0000_0000);

        // Element k lands exactly at E0+k+CD+1; the cycle before it still holds the old 0.125.
        drive(64'h0, $realtobits(4.0), 1'b1, 1'b0, 1'b0);
        for (int cyc = 1; cyc <= NL; cyc++) begin
            @(posedge clk); #1;
            for (int k = 0; k < SA * SB; k++) begin
                if (cyc == k + CD + 1)
                    check($sformatf("elem%0d_arrival", k), result[k / SB][k % SB], $realtobits(real'(k) / 4.0));
                else if (cyc == k + CD)
                    check($sformatf("elem%0d_early", k), result[k / SB][k % SB], 64'h3FC0_0000_0000_0000);
            end
        end
        wait_f(NL, NL, 1'b0, 1'b0, "ramp_timing");
        check("ramp_r7_c7", result[7][7], $realtobits(15.75));

        drive($realtobits(2.0), $realtobits(16.0), 1'b0, 1'b0, 1'b0);
        repeat (19) begin @(posedge clk); #1; end
        for (int i = 0; i < SA; i++)
            for (int j = 0; j < SB; j++) mat[i][j] = $realtobits(5.0);
        norm  = $realtobits(1.0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("ignored_start_busy", busy, 64'h1);
        wait_f(20, NL, 1'b0, 1'b0, "ignored_start");

        drive(64'h0, $realtobits(4.0), 1'b1, 1'b0, 1'b0);
        repeat (29) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        check("midrst_busy", busy, 64'h0);
        check("midrst_f", f, 64'h0);
        count_nonzero("midrst_result_nonzero_count");
        repeat (3) begin @(posedge clk); #1; end
        drive($realtobits(3.0), $realtobits(3.0), 1'b0, 1'b0, 1'b0);
        wait_f(0, NL, 1'b0, 1'b0, "after_reset");

`ifdef DOUBLE_NORMALISE_ERR_EN
        drive($realtobits(1.0), $realtobits(1.0e-10), 1'b0, 1'b0, 1'b1);
        wait_f(0, NL, 1'b0, 1'b1, "err_set");
        drive($realtobits(3.0), $realtobits(3.0), 1'b0, 1'b0, 1'b0);
        wait_f(0, NL, 1'b0, 1'b0, "err_clear");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/double_matrix_normalise.md
# double_matrix_normalise

Divides every element of a SIZE_A×SIZE_B double-precision matrix by a scalar norm. It sits directly downstream of the Frobenius norm stage and produces the unit-Frobenius-norm matrix for the whitening/ICA path. Elements stream serially in row-major order through one pipelined fp_div instance. The block uses a start/finish handshake consistent with the rest of the fp_double datapath.

## Interface
Parameters:
- SIZE_A, 8, matrix rows
- SIZE_B, 8, matrix columns
- CYCLES_D, 10, fixed latency of the fp_div IP in clock-enabled cycles

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request; accepted only in IDLE
- mat  in  double[SIZE_A][SIZE_B]  input matrix; sampled on the accepting edge
- norm  in  double  divisor; sampled on the accepting edge
- result  out  double[SIZE_A][SIZE_B]  normalised matrix
- busy  out  1  high from acceptance until f rises
- f  out  1  finish level; held high until the next accepted start
- zero_norm  out  1  norm was zero or subnormal on the last run
- err  out  1  sticky divider overflow/NaN on the last run (only with the macro)

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE, start=1:
  - latch mat into mat_q and norm into norm_q, with norm_q sign bit forced to 0
  - clear f, zero_norm and err; set busy
  - if norm exponent field == 0: set zero_norm, go to DONE
  - otherwise go to ISSUE with issue index k=0
- ISSUE:
  - each cycle, present dataa=mat_q[k/SIZE_B][k%SIZE_B] and datab=norm_q with clk_en=1
  - push k into a CYCLES_D-deep valid/index shift register; k++
  - after k=N-1 (N=SIZE_A·SIZE_B), go to DRAIN
- DRAIN:
  - divider clk_en stays 1
  - when the shift register output is valid, write the divider result to result[idx/SIZE_B][idx%SIZE_B]
  - after idx N-1 is written, go to DONE
- DONE: assert f, deassert busy, go to IDLE in the same edge.
- Zero-norm path: result is written to all +0.0 in one cycle. No division occurs.
- start while busy is ignored, with no effect on the run in progress.
- Index arithmetic uses $clog2(N)-bit counters; no wrap occurs within a run.

## Timing
- Reset values: result all 0, busy=0, f=0, zero_norm=0, err=0; state IDLE; shift register valid bits cleared.
- Accepting edge = E0. First issue occurs in the cycle after E0.
- Normal run: f is high after edge E0 + N + CYCLES_D + 1. For the 8×8 default with CYCLES_D=10, that is E0+75.
- Zero-norm run: f is high after E0+2.
- Element k's result appears in result at edge E0 + k + CYCLES_D + 1.
- result is valid as a whole only while f=1. Partial updates are visible while busy.
- Back-to-back: start may be accepted on the edge after f rises.
- Reset mid-run:
  - everything returns to reset values on the next edge
  - in-flight divider results are discarded because the valid bits are cleared
  - the divider is additionally reset via its aclr port tied to rst

## Configuration
- DOUBLE_NORMALISE_ERR_EN:
  - Defined: the fp_div overflow and nan flags are ORed into err on every valid write. err is sticky until the next accepted start.
  - Undefined: err is tied to 0 and the flag outputs of fp_div are left unconnected.

## Structure
- The double typedef comes from package fp_double, alongside new helpers that belong there:
  - DOUBLE_ZERO constant
  - exponent-field extraction function
- One sub-module: fp_div, the vendor double divider IP. Its ports are aclr, clock, clk_en, dataa, datab, result, overflow, nan, zero, division_by_zero.
- The FSM, the index shift register and the result register array live in this module.

## Test plan
- mat all 2.0, norm 16.0, start pulse:
  - result all 0.125 (0x3FC0000000000000)
  - f rises at E0+75
  - zero_norm=0
- mat[i][j]=i·8+j, norm 4.0:
  - result[i][j]=(i·8+j)/4; spot check result[7][7]=15.75
  - element k appears at E0+k+11
- norm 0.0 with a random mat: result all 0, zero_norm=1, f at E0+2, fp_div clk_en never asserted.
- Second start pulsed 20 cycles into a run with different mat: ignored; results match the first run; f at E0+75.
- rst asserted at E0+30, then a new start with mat all 3.0, norm 3.0: result all 1.0 with no stale entries; f 75 cycles after the new start.
- With the macro defined, mat[0][0]=1e308, norm=1e-10: err=1 at completion. The next start with valid data clears err.
